// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: counters, syncs, blanking, frame strobe/count
// Flags are decoded from next-state counters so they share the counters' register stage.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (rst) begin
      hcount_d = '0;
      vcount_d = '0;
    end else if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
    end else begin
      hcount_d = hcount_q + 11'd1;
    end

    // Reset lands on (0,0), which decodes to deasserted syncs and no blanking.
    hsync_d       = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    hblnk_d       = (hcount_d >= H_ACT);
    vblnk_d       = (vcount_d >= V_ACT);
    frame_start_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);

    frame_count_d = frame_count_q;
    if (rst) begin
      frame_count_d = '0;
    end else if (frame_start_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    hcount_q      <= hcount_d;
    vcount_q      <= vcount_d;
    hsync_q       <= hsync_d;
    vsync_q       <= vsync_d;
    hblnk_q       <= hblnk_d;
    vblnk_q       <= vblnk_d;
    frame_start_q <= frame_start_d;
    frame_count_q <= frame_count_d;
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen
// Small-raster instances (both sync polarities) plus one default-size instance.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int FRAME_A = (HA + HF + HS + HB) * (VA + VF + VS + VB);

  typedef logic [42:0] vec_t;
  typedef struct packed {
    logic rst;
    vec_t a;
    vec_t b;
    vec_t c;
  } exp_s;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic        hs_a, vs_a, hb_a, vb_a, fs_a;
  logic        hs_b, vs_b, hb_b, vb_b, fs_b;
  logic        hs_c, vs_c, hb_c, vb_c, fs_c;
  logic [15:0] fc_a, fc_b, fc_c;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a),
    .hblnk(hb_a), .vblnk(vb_a), .frame_start(fs_a), .frame_count(fc_a));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
    .hblnk(hb_b), .vblnk(vb_b), .frame_start(fs_b), .frame_count(fc_b));

  vga_timing_gen dut_c (
    .clk(clk), .rst(rst), .hcount(hc_c), .vcount(vc_c), .hsync(hs_c), .vsync(vs_c),
    .hblnk(hb_c), .vblnk(vb_c), .frame_start(fs_c), .frame_count(fc_c));

  vec_t act_a, act_b, act_c;
  assign act_a = {hc_a, vc_a, hs_a, vs_a, hb_a, vb_a, fs_a, fc_a};
  assign act_b = {hc_b, vc_b, hs_b, vs_b, hb_b, vb_b, fs_b, fc_b};
  assign act_c = {hc_c, vc_c, hs_c, vs_c, hb_c, vb_c, fs_c, fc_c};

  always #5 clk = ~clk;

  // Reference: the raster position is just elapsed cycles since reset, split by line and frame length.
  function automatic vec_t model(input int t, input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input logic pol, input int off);
    int   ht, vt, h, line, v, fr;
    logic hsy, vsy;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    h    = t % ht;
    line = t / ht;
    v    = line % vt;
    fr   = line / vt;
    hsy  = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    vsy  = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
    return {11'(h), 11'(v), hsy, vsy, logic'(h >= ha), logic'(v >= va),
            logic'(h == 0 && v == 0), 16'(off + fr)};
  endfunction

  exp_s q[$];
  int   t = 0;
  int   off_a = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    exp_s e;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0;
        off_a = 0;
      end else begin
        t++;
      end
      e.rst = rst;
      e.a = model(t, HA, HF, HS, HB, VA, VF, VS, VB, 1'b1, off_a);
      e.b = model(t, HA, HF, HS, HB, VA, VF, VS, VB, 1'b0, 0);
      e.c = model(t, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, 0);
      q.push_back(e);
    end
  end

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got h=%0d v=%0d flags(hs,vs,hb,vb,fs)=%b fc=%0d, expected h=%0d v=%0d flags=%b fc=%0d",
               name, t, act[42:32], act[31:21], act[20:16], act[15:0],
               exp[42:32], exp[31:21], exp[20:16], exp[15:0]);
    end
  endtask

  initial begin
    exp_s e;
    int   cyc = 0;
    int   last_fs = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at cycle %0d: got 0 entries, expected at least 1", cyc);
      end else begin
        e = q.pop_front();
        check_vec("raster_pol1", act_a, e.a);
        check_vec("raster_pol0", act_b, e.b);
        check_vec("raster_1024x768", act_c, e.c);
        if (e.rst) begin
          last_fs = cyc;
        end else if (fs_a) begin
          if (last_fs >= 0) begin
            checks++;
            if (cyc - last_fs != FRAME_A) begin
              errors++;
              $display("FAIL frame_period: got %0d cycles, expected %0d", cyc - last_fs, FRAME_A);
            end
          end
          last_fs = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout at t=%0d, expected completion", t);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Mid-frame reset at frame_count 5, line 6, pixel 12 of the small raster.
    while (t != 5 * FRAME_A + 6 * 25 + 12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Long free run covers full lines of the default-size raster (hsync window, line wrap).
    repeat (3000) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1500, 1)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      rst = 1'b0;
    end

    // Preload frame_count to 65535 just before a frame boundary, then let it wrap.
    while ((t % FRAME_A) != FRAME_A - 100) @(negedge clk);
    #1;
    force dut_a.frame_count_q = 16'hFFFF;
    off_a = 65535 - t / FRAME_A;
    @(negedge clk);
    #1;
    release dut_a.frame_count_q;
    repeat (FRAME_A + 50) @(negedge clk);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 1024x768 display pipeline. It produces the pixel/line counters, sync pulses and blanking flags that feed the drawing chain: draw_background first, then the sprite/overlay stages. All outputs are registered and mutually consistent: in any cycle, every flag describes the pixel at the current `hcount`/`vcount`. It also provides a frame-start strobe and a frame counter, which game logic uses to update once per frame.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, hsync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `SYNC_POL`, 1'b1, asserted level of hsync/vsync (1 = active-high)

Ports:
- `clk` in 1: pixel clock, 65 MHz
- `rst` in 1: synchronous, active-high reset
- `hcount` out 11: pixel index in line, 0..H_TOTAL-1
- `vcount` out 11: line index in frame, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync, level per SYNC_POL
- `vsync` out 1: vertical sync, level per SYNC_POL
- `hblnk` out 1: high when hcount >= H_ACTIVE
- `vblnk` out 1: high when vcount >= V_ACTIVE
- `frame_start` out 1: one-cycle pulse when hcount==0 and vcount==0
- `frame_count` out 16: completed-frame counter, wraps modulo 2^16

## Operation
- Totals: H_TOTAL = sum of the H params = 1344; V_TOTAL = sum of the V params = 806.
- Horizontal counter:
  - Increments every cycle.
  - At H_TOTAL-1 it wraps to 0 on the next cycle.
- Vertical counter:
  - Increments only on the cycle where hcount wraps.
  - At V_TOTAL-1 (together with the hcount wrap) it wraps to 0.
- Sync windows, inclusive:
  - hsync is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [1048, 1183].
  - vsync is asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [771, 776].
  - vsync spans whole lines and changes only on the hcount 0 boundary.
- Decode: all flags are computed from the next-state counter values and registered, so there is zero skew between counters and flags.
- frame_count increments by 1 in the same cycle that frame_start is asserted. The pulse that leaves reset does not increment it.
- Reset behaviour, at the rising edge where `rst`=1:
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hsync=vsync=~SYNC_POL (deasserted).
  - frame_count=0, frame_start=1, because position (0,0) is the start of a frame.
- Reset mid-frame forces this state immediately. The raster resumes from (0,0) on the first cycle after `rst` deasserts, which presents hcount=1.
- No enable input: the generator free-runs whenever it is out of reset.

## Timing
- Latency: none between counters and flags; they come from the same register stage.
- The downstream draw stage adds 1 cycle; this is not this block's concern.
- Line period: 1344 cycles. Frame period: 1344 × 806 = 1,083,264 cycles.
- hsync: 136 cycles high per line. hblnk: 320 cycles per line.
- vblnk: 38 lines per frame. vsync: 6 lines per frame.
- frame_start:
  - High exactly 1 cycle per frame, in the cycle that presents (0,0).
  - Never high in two consecutive cycles.
- Simultaneous wraps: on the cycle where hcount goes 1343→0 and vcount goes 805→0:
  - vblnk drops to 0.
  - frame_start goes to 1.
  - frame_count increments.
- frame_count wraps from 65535 to 0.

## Test plan
- Reset: hold `rst` for 3 cycles.
  - During reset: all outputs at their reset values, frame_start=1, frame_count=0.
  - First cycle after release: hcount=1, vcount=0, frame_start=0.
- Line wrap: at hcount=1343, vcount=0.
  - Next cycle: hcount=0, vcount=1.
  - hblnk was 1 from 1024 to 1343 and is 0 at hcount=0.
- hsync window: over one line, hsync is asserted for exactly 136 consecutive cycles, first at hcount=1048 and last at 1183.
  - Repeat with SYNC_POL=0: same window, inverted level.
- Frame wrap: at (1343, 805), the next cycle presents (0,0) with frame_start=1, frame_count=1 and vblnk=0.
  - Count 1,083,264 cycles between successive frame_start pulses.
  - vsync is asserted for exactly lines 771..776 (6 × 1344 cycles).
- Reset mid-frame: assert `rst` for 1 cycle at (500, 400) with frame_count=5.
  - Result: (0,0), frame_count=0, sync deasserted.
  - The raster then restarts normally.
- Frame counter wrap: run until frame_count=65535 (or run the bench with a force), then complete one frame → frame_count=0.
